// File: rtl/spi_ram_responder.sv
// SPI mode-0 responder fronting a small word RAM: 8-bit opcode, 24-bit address, DATA_W data bits.
// All SPI inputs are resynchronised into clk; memory is written only when a full write frame completes.
module spi_ram_responder #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 16,
  parameter logic [7:0]  CMD_WRITE = 8'h02,
  parameter logic [7:0]  CMD_READ  = 8'h03
) (
  input  logic clk,
  input  logic nrst,
  input  logic sck,
  input  logic css,
  input  logic sdi,
  output logic sdo,
  output logic busy
);

  localparam int unsigned CntW = $clog2(32 + DATA_W);
  localparam logic [CntW-1:0] CmdLast  = CntW'(7);
  localparam logic [CntW-1:0] AddrLast = CntW'(31);
  localparam logic [CntW-1:0] DataLast = CntW'(31 + DATA_W);

  typedef enum logic [2:0] {StIdle, StCmd, StAddr, StWrData, StRdData, StDone} state_e;

  state_e              state;
  logic [2:0]          sck_sync, css_sync;
  logic [1:0]          sdi_sync;
  logic [CntW-1:0]     cnt;
  logic [7:0]          cmd;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wdat, dout, wr_data;
  logic                is_wr, rd_pend, wr_en;
  logic [DATA_W-1:0]   mem [2**ADDR_W];

  logic sck_rise, sck_fall, css_rise, css_fall, sdi_s;
  logic [7:0] cmd_next;

  // Bit [1] is the synchronised level, bit [2] its previous sample for edge detection.
  always_comb begin
    sck_rise = sck_sync[1] & ~sck_sync[2];
    sck_fall = ~sck_sync[1] & sck_sync[2];
    css_rise = css_sync[1] & ~css_sync[2];
    css_fall = ~css_sync[1] & css_sync[2];
    sdi_s    = sdi_sync[1];
    cmd_next = {cmd[6:0], sdi_s};
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sck_sync <= 3'b000;
      css_sync <= 3'b111;
      sdi_sync <= 2'b00;
    end else begin
      sck_sync <= {sck_sync[1:0], sck};
      css_sync <= {css_sync[1:0], css};
      sdi_sync <= {sdi_sync[0], sdi};
    end
  end

  // Memory has no reset so contents survive nrst.
  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= StIdle;
      sdo     <= 1'b0;
      busy    <= 1'b0;
      cnt     <= '0;
      cmd     <= '0;
      addr    <= '0;
      wdat    <= '0;
      dout    <= '0;
      wr_data <= '0;
      is_wr   <= 1'b0;
      rd_pend <= 1'b0;
      wr_en   <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (css_rise) begin
        state   <= StIdle;
        busy    <= 1'b0;
        sdo     <= 1'b0;
        rd_pend <= 1'b0;
      end else begin
        case (state)
          StIdle: begin
            if (css_fall) begin
              state <= StCmd;
              busy  <= 1'b1;
              cnt   <= '0;
            end
          end
          StCmd: begin
            if (sck_rise) begin
              cnt <= cnt + 1'b1;
              cmd <= cmd_next;
              if (cnt == CmdLast) begin
                if (cmd_next == CMD_WRITE) begin
                  is_wr <= 1'b1;
                  state <= StAddr;
                end else if (cmd_next == CMD_READ) begin
                  is_wr <= 1'b0;
                  state <= StAddr;
                end else begin
                  state <= StDone;
                end
              end
            end
          end
          StAddr: begin
            if (sck_rise) begin
              cnt  <= cnt + 1'b1;
              addr <= {addr[ADDR_W-2:0], sdi_s};
              if (cnt == AddrLast) begin
                if (is_wr) begin
                  state <= StWrData;
                end else begin
                  state   <= StRdData;
                  rd_pend <= 1'b1;
                end
              end
            end
          end
          StWrData: begin
            if (sck_rise) begin
              cnt  <= cnt + 1'b1;
              wdat <= {wdat[DATA_W-2:0], sdi_s};
              if (cnt == DataLast) begin
                wr_data <= {wdat[DATA_W-2:0], sdi_s};
                wr_en   <= 1'b1;
                state   <= StDone;
              end
            end
          end
          StRdData: begin
            // Load happens one clk after entry, well before the first falling edge.
            if (rd_pend) begin
              dout    <= mem[addr];
              rd_pend <= 1'b0;
            end else if (sck_fall) begin
              sdo  <= dout[DATA_W-1];
              dout <= {dout[DATA_W-2:0], 1'b0};
            end
          end
          StDone:  ;
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_ram_responder.sv
// Self-checking bench for spi_ram_responder: directed frames then randomized ones
// against an associative word-store model indexed by the low address byte.
module tb_spi_ram_responder;

  logic clk = 1'b0;
  logic nrst, sck, css, sdi, sdo, busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] mdl   [256];
  bit          known [256];

  spi_ram_responder dut (
    .clk  (clk),
    .nrst (nrst),
    .sck  (sck),
    .css  (css),
    .sdi  (sdi),
    .sdo  (sdo),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SPI frame: nbits sck cycles, optional nrst pulse at bit rst_at, then css high for gap clks.
  task automatic frame(input logic [7:0] op, input logic [23:0] addr, input logic [15:0] wd,
                       input int nbits, input int rst_at, input int gap,
                       output logic [47:0] cap, output logic busy_mid);
    logic [47:0] bits;
    bit aborted;
    bits     = {op, addr, wd};
    cap      = '0;
    busy_mid = 1'b0;
    aborted  = 1'b0;
    @(negedge clk);
    css = 1'b0;
    wait_clk(6);
    for (int i = 0; i < nbits && !aborted; i++) begin
      if (i == rst_at) begin
        nrst = 1'b0;
        #1;
        check("rst_mid_sdo", {47'b0, sdo}, 48'd0);
        check("rst_mid_busy", {47'b0, busy}, 48'd0);
        css = 1'b1;
        sck = 1'b0;
        wait_clk(3);
        nrst = 1'b1;
        aborted = 1'b1;
      end else begin
        sdi = (i < 48) ? bits[47-i] : 1'($urandom);
        wait_clk(6);
        if (i < 48) cap[47-i] = sdo;
        if (i == 10) busy_mid = busy;
        sck = 1'b1;
        wait_clk(6);
        sck = 1'b0;
      end
    end
    wait_clk(6);
    css = 1'b1;
    wait_clk(gap);
  endtask

  // Runs a frame and checks it against the model; returns captured sdo bits.
  task automatic run(input string tag, input logic [7:0] op, input logic [23:0] addr,
                     input logic [15:0] wd, input int nbits, input int rst_at, input int gap,
                     output logic [47:0] cap);
    logic bm;
    logic [7:0] a;
    a = addr[7:0];
    frame(op, addr, wd, nbits, rst_at, gap, cap, bm);
    if (rst_at < 0) begin
      if (op == 8'h03 && known[a]) check({tag, "_rdata"}, cap, {32'b0, mdl[a]});
      else if (op == 8'h03) check({tag, "_rprefix"}, {16'b0, cap[47:16]}, 48'd0);
      else check({tag, "_sdo0"}, cap, 48'd0);
      if (nbits > 10) check({tag, "_busy_mid"}, {47'b0, bm}, 48'd1);
      if (op == 8'h02 && nbits >= 48) begin
        mdl[a]   = wd;
        known[a] = 1'b1;
      end
    end
    if (gap >= 5) check({tag, "_busy_end"}, {47'b0, busy}, 48'd0);
  endtask

  initial begin
    logic [47:0] cap;
    logic [7:0]  op, lo;
    logic [23:0] ad;
    int          nb;
    for (int i = 0; i < 256; i++) known[i] = 1'b0;
    nrst = 1'b0;
    sck  = 1'b0;
    css  = 1'b1;
    sdi  = 1'b0;
    wait_clk(3);
    check("reset_sdo", {47'b0, sdo}, 48'd0);
    check("reset_busy", {47'b0, busy}, 48'd0);
    nrst = 1'b1;
    wait_clk(4);

    run("wr10", 8'h02, 24'h000010, 16'hA5C3, 48, -1, 12, cap);
    run("rd10", 8'h03, 24'h000010, 16'h0000, 48, -1, 12, cap);
    check("rd10_const", {32'b0, cap[15:0]}, 48'h0000_0000_A5C3);

    run("wr105", 8'h02, 24'h000105, 16'hBEEF, 48, -1, 12, cap);
    run("rd005", 8'h03, 24'h000005, 16'h0000, 48, -1, 12, cap);
    check("alias_const", {32'b0, cap[15:0]}, 48'h0000_0000_BEEF);

    run("wr20", 8'h02, 24'h000020, 16'h1234, 48, -1, 12, cap);
    run("wr20_abort", 8'h02, 24'h000020, 16'hFFFF, 40, -1, 12, cap);
    run("rd20", 8'h03, 24'h000020, 16'h0000, 48, -1, 12, cap);
    check("abort_const", {32'b0, cap[15:0]}, 48'h0000_0000_1234);

    run("badop", 8'h05, 24'h000020, 16'hFFFF, 48, -1, 12, cap);
    run("rd20b", 8'h03, 24'h000020, 16'h0000, 48, -1, 12, cap);

    run("wr30", 8'h02, 24'h000030, 16'h7777, 48, -1, 12, cap);
    run("wr30_rst", 8'h02, 24'h000030, 16'h0BAD, 48, 20, 12, cap);
    run("rd30", 8'h03, 24'h000030, 16'h0000, 48, -1, 12, cap);
    check("rst_const", {32'b0, cap[15:0]}, 48'h0000_0000_7777);

    run("wr11", 8'h02, 24'h000011, 16'h5A5A, 48, -1, 12, cap);
    run("b2b_rd10", 8'h03, 24'h000010, 16'h0000, 48, -1, 2, cap);
    run("b2b_rd11", 8'h03, 24'h000011, 16'h0000, 48, -1, 12, cap);
    check("b2b_const", {32'b0, cap[15:0]}, 48'h0000_0000_5A5A);

    for (int k = 0; k < 24; k++) begin
      lo = 8'h40 + 8'($urandom_range(0, 7));
      ad = {16'($urandom), lo};
      nb = 48;
      case ($urandom_range(0, 9))
        0: op = 8'($urandom_range(4, 255));
        1, 2, 3, 4: begin
          op = 8'h02;
          if ($urandom_range(0, 5) == 0) nb = $urandom_range(9, 47);
        end
        default: op = 8'h03;
      endcase
      run($sformatf("rnd%0d", k), op, ad, 16'($urandom), nb, -1,
          ($urandom_range(0, 1) == 1) ? 2 : 8, cap);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
